// File: rtl/car_dash_pkg.sv
// rtl/car_dash_pkg.sv - shared move encodings, FSM states and result layout for move_car_lanes
package car_dash_pkg;

    localparam logic [1:0] MV_NONE  = 2'b00;
    localparam logic [1:0] MV_LEFT  = 2'b10;
    localparam logic [1:0] MV_RIGHT = 2'b01;

    localparam int HIT_BIT = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    function automatic logic is_legal_move(input logic [1:0] mv);
        return (mv == MV_LEFT) || (mv == MV_RIGHT);
    endfunction

endpackage

// File: rtl/immunity_timer.sv
// rtl/immunity_timer.sv - post-hit immunity flag, cleared after IMMUNE_TICKS evaluation ticks
module immunity_timer #(
    parameter int IMMUNE_TICKS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic tick,
    output logic active
);

    logic [7:0] r_count;
    logic       r_active;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_active <= 1'b0;
            r_count  <= 8'd0;
        end else if (start) begin
            r_active <= 1'b1;
            r_count  <= 8'd0;
        end else if (tick && r_active) begin
            if (r_count == 8'(IMMUNE_TICKS - 1)) begin
                r_active <= 1'b0;
                r_count  <= 8'd0;
            end else begin
                r_count <= r_count + 8'd1;
            end
        end
    end

    assign active = r_active;

endmodule

// File: rtl/move_car_lanes.sv
// rtl/move_car_lanes.sv - lane-change/collision evaluator; MOVE_CAR_LIVES_EN enables life counting and game_over
module move_car_lanes
    import car_dash_pkg::*;
#(
    parameter int  LANES        = 6,
    parameter int  IMMUNE_TICKS = 4,
    parameter int  LIVES        = 3,
    localparam int POS_W        = $clog2(LANES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    input  logic [LANES-1:0] next_row,
    input  logic [LANES-1:0] head_row,
    input  logic [POS_W-1:0] position,
    input  logic [1:0]       attempt_move,
    output logic [2:0]       move_result,
    output logic             result_valid,
    output logic             immune,
    output logic [3:0]       lives_left,
    output logic             game_over
);

    localparam logic [POS_W-1:0] LAST_LANE = POS_W'(LANES - 1);
    localparam logic [POS_W:0]   LANES_W   = (POS_W + 1)'(LANES);
    localparam logic [LANES-1:0] LANE0     = LANES'(1);

    state_t           r_state, w_next_state;
    logic [1:0]       r_latch;
    logic [2:0]       r_move_result;
    logic             r_result_valid;
    logic             w_start, w_eval, w_pos_ok, w_hit_raw, w_hit;
    logic [1:0]       w_move;
    logic [POS_W-1:0] w_target;
    logic [2:0]       w_result;

    assign w_start = step && !game_over;
    assign w_eval  = (r_state == ST_EVAL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_next_state = ST_EVAL;
            ST_EVAL: w_next_state = ST_HOLD;
            ST_HOLD: if (!step) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Blocked edge moves collapse to MV_NONE, so they share the stay-in-lane hit test.
    always_comb begin
        w_pos_ok = ({1'b0, position} < LANES_W);
        w_move   = MV_NONE;
        w_target = position;
        if (r_latch == MV_LEFT && position != LAST_LANE) begin
            w_move   = MV_LEFT;
            w_target = position + 1'b1;
        end else if (r_latch == MV_RIGHT && position != '0) begin
            w_move   = MV_RIGHT;
            w_target = position - 1'b1;
        end
        if (w_move == MV_NONE) w_hit_raw = |(next_row & (LANE0 << position));
        else                   w_hit_raw = |((next_row | head_row) & (LANE0 << w_target));
        w_hit    = w_pos_ok && !immune && w_hit_raw;
        w_result = 3'b000;
        if (w_pos_ok) begin
            w_result[HIT_BIT] = w_hit;
            w_result[1:0]     = w_move;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_latch        <= MV_NONE;
            r_move_result  <= 3'b000;
            r_result_valid <= 1'b0;
        end else begin
            r_result_valid <= w_eval;
            if (w_eval) r_move_result <= w_result;
            if (r_state == ST_IDLE && !w_start && r_latch == MV_NONE && is_legal_move(attempt_move))
                r_latch <= attempt_move;
            else if (r_state == ST_HOLD && !step)
                r_latch <= MV_NONE;
        end
    end

    immunity_timer #(
        .IMMUNE_TICKS(IMMUNE_TICKS)
    ) u_immunity (
        .clk   (clk),
        .reset (reset),
        .start (w_eval && w_hit),
        .tick  (w_eval),
        .active(immune)
    );

`ifdef MOVE_CAR_LIVES_EN
    logic [3:0] r_lives;
    logic       r_game_over;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lives     <= 4'(LIVES);
            r_game_over <= 1'b0;
        end else if (w_eval && w_hit) begin
            r_lives <= r_lives - 4'd1;
            if (r_lives == 4'd1) r_game_over <= 1'b1;
        end
    end

    assign lives_left = r_lives;
    assign game_over  = r_game_over;
`else
    assign lives_left = 4'(LIVES);
    assign game_over  = 1'b0;
`endif

    assign move_result  = r_move_result;
    assign result_valid = r_result_valid;

endmodule

// File: tb/tb_move_car_lanes.sv
// tb/tb_move_car_lanes.sv - randomized model-checked bench for move_car_lanes
module tb_move_car_lanes;

    localparam int LANES        = 6;
    localparam int IMMUNE_TICKS = 4;
    localparam int LIVES        = 3;
    localparam int POS_W        = $clog2(LANES);
`ifdef MOVE_CAR_LIVES_EN
    localparam bit LIVES_EN = 1'b1;
`else
    localparam bit LIVES_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             step = 1'b0;
    logic [LANES-1:0] next_row = '0;
    logic [LANES-1:0] head_row = '0;
    logic [POS_W-1:0] position = '0;
    logic [1:0]       attempt_move = 2'b00;
    logic [2:0]       move_result;
    logic             result_valid;
    logic             immune;
    logic [3:0]       lives_left;
    logic             game_over;

    move_car_lanes #(
        .LANES(LANES), .IMMUNE_TICKS(IMMUNE_TICKS), .LIVES(LIVES)
    ) dut (
        .clk(clk), .reset(reset), .step(step), .next_row(next_row), .head_row(head_row),
        .position(position), .attempt_move(attempt_move), .move_result(move_result),
        .result_valid(result_valid), .immune(immune), .lives_left(lives_left), .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] mr;
        logic       imm;
        logic [3:0] lives;
        logic       over;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       cmp_e;
    int         n_cmp = 0;
    int         n_fail = 0;
    int         n_valid = 0;
    logic [1:0] m_latch;
    int         m_imm_left;
    int         m_lives;
    bit         m_over;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_latch    = 2'b00;
        m_imm_left = 0;
        m_lives    = LIVES;
        m_over     = 1'b0;
        exp_q.delete();
    endfunction

    // Immunity modelled as evaluations still to be absorbed, rather than an up-counter.
    function automatic exp_t model_eval(input int pos, input logic [LANES-1:0] nr, input logic [LANES-1:0] hr);
        exp_t       e;
        logic [1:0] mv = 2'b00;
        bit         hit = 1'b0;
        int         tgt = pos;
        if (pos < LANES) begin
            if (m_latch == 2'b10 && pos < LANES - 1) begin mv = 2'b10; tgt = pos + 1; end
            else if (m_latch == 2'b01 && pos > 0) begin mv = 2'b01; tgt = pos - 1; end
            hit = (mv == 2'b00) ? nr[pos] : (nr[tgt] | hr[tgt]);
        end
        if (m_imm_left > 0) begin
            hit = 1'b0;
            m_imm_left--;
        end else if (hit) begin
            m_imm_left = IMMUNE_TICKS;
            if (LIVES_EN) begin
                m_lives--;
                if (m_lives == 0) m_over = 1'b1;
            end
        end
        e.mr    = {hit, mv};
        e.imm   = (m_imm_left > 0);
        e.lives = 4'(m_lives);
        e.over  = m_over;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!reset && result_valid) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                check("result_valid_unexpected", 32'(result_valid), 32'd0);
            end else begin
                cmp_e = exp_q.pop_front();
                check("move_result", 32'(move_result), 32'(cmp_e.mr));
                check("immune", 32'(immune), 32'(cmp_e.imm));
                check("lives_left", 32'(lives_left), 32'(cmp_e.lives));
                check("game_over", 32'(game_over), 32'(cmp_e.over));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        cyc(1);
        reset = 1'b1;
        step = 1'b0;
        attempt_move = 2'b00;
        cyc(1);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_move_result"}, 32'(move_result), 32'd0);
        check({tag, "_result_valid"}, 32'(result_valid), 32'd0);
        check({tag, "_immune"}, 32'(immune), 32'd0);
        check({tag, "_lives_left"}, 32'(lives_left), 32'(LIVES));
        check({tag, "_game_over"}, 32'(game_over), 32'd0);
    endtask

    task automatic request(input logic [1:0] mv);
        attempt_move = mv;
        if (m_latch == 2'b00 && (mv == 2'b10 || mv == 2'b01)) m_latch = mv;
        cyc(1);
        attempt_move = 2'b00;
    endtask

    task automatic tick(input int pos, input logic [LANES-1:0] nr, input logic [LANES-1:0] hr,
                        input int hold, input logic [1:0] att);
        position = POS_W'(pos);
        next_row = nr;
        head_row = hr;
        attempt_move = att;
        step = 1'b1;
        if (!m_over) exp_q.push_back(model_eval(pos, nr, hr));
        cyc(hold);
        step = 1'b0;
        attempt_move = 2'b00;
        cyc(3);
        if (!m_over) m_latch = 2'b00;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int v0;
        model_reset();
        cyc(2);
        reset = 1'b0;
        check_reset_vals("reset");

        request(2'b10);
        tick(2, 6'b001000, 6'b000000, 1, 2'b00);
        check("lit_hit_left_mr", 32'(move_result), 32'b110);
        check("lit_hit_left_immune", 32'(immune), 32'd1);
        check("lit_hit_left_lives", 32'(lives_left), LIVES_EN ? 32'd2 : 32'd3);

        for (int i = 0; i < 3; i++) begin
            tick(2, '1, '1, 2, 2'b00);
            check("lit_immune_tick_mr", 32'(move_result), 32'b000);
            check("lit_immune_tick_immune", 32'(immune), 32'd1);
        end
        tick(2, '1, '1, 1, 2'b00);
        check("lit_immune_expire_immune", 32'(immune), 32'd0);
        tick(2, '1, '1, 1, 2'b00);
        check("lit_post_immune_hit", 32'(move_result), 32'b100);

        do_reset();
        request(2'b10);
        tick(5, 6'b000000, 6'b000000, 1, 2'b00);
        check("lit_edge_left_clear", 32'(move_result), 32'b000);
        request(2'b10);
        tick(5, 6'b100000, 6'b000000, 1, 2'b00);
        check("lit_edge_left_hit", 32'(move_result), 32'b100);

        do_reset();
        request(2'b01);
        request(2'b10);
        tick(3, 6'b000000, 6'b000000, 1, 2'b00);
        check("lit_first_latch_wins", 32'(move_result), 32'b001);

        do_reset();
        for (int h = 0; h < 3; h++) begin
            tick(0, 6'b000001, 6'b000000, 1, 2'b00);
            for (int k = 0; k < IMMUNE_TICKS; k++) tick(0, 6'b000000, 6'b000000, 1, 2'b00);
        end
        check("lit_three_hits_over", 32'(game_over), 32'(LIVES_EN));
        check("lit_three_hits_lives", 32'(lives_left), LIVES_EN ? 32'd0 : 32'(LIVES));
        v0 = n_valid;
        tick(1, 6'b000000, 6'b000000, 2, 2'b00);
        check("lit_step_after_over_pulses", 32'(n_valid - v0), LIVES_EN ? 32'd0 : 32'd1);

        do_reset();
        tick(0, 6'b000001, 6'b000000, 1, 2'b00);
        v0 = n_valid;
        position = '0;
        step = 1'b1;
        cyc(1);
        #2 reset = 1'b1;
        #1 check_reset_vals("abort_eval");
        step = 1'b0;
        cyc(1);
        reset = 1'b0;
        model_reset();
        cyc(3);
        check("abort_eval_no_pulse", 32'(n_valid - v0), 32'd0);

        tick(0, 6'b000001, 6'b000000, 1, 2'b00);
        request(2'b10);
        position = '0;
        step = 1'b1;
        exp_q.push_back(model_eval(0, 6'b000001, 6'b000000));
        cyc(3);
        #2 reset = 1'b1;
        #1 check_reset_vals("reset_in_hold");
        step = 1'b0;
        cyc(1);
        reset = 1'b0;
        model_reset();

        for (int it = 0; it < 400; it++) begin
            if (m_over || $urandom_range(0, 49) == 0) do_reset();
            repeat ($urandom_range(0, 3)) request(2'($urandom_range(0, 3)));
            tick($urandom_range(0, (1 << POS_W) - 1), LANES'($urandom & $urandom),
                 LANES'($urandom & $urandom), $urandom_range(1, 3),
                 ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 2)) : 2'b00);
        end

        cyc(2);
        check("pending_results", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
